// File: rtl/mux_b_if.sv
// mux_b_if -- operand-B select bus.
//   ext_in          : sign-extended immediate operand
//   data_memory_in  : operand read from data memory
//   sel_B           : 0 selects ext_in, 1 selects data_memory_in
//   load_en         : capture enable for the registered copy
//   mux_B_out       : combinational selected operand
//   mux_B_q         : registered selected operand
//   sel_q           : registered copy of sel_B
// The master modport belongs to whoever drives the operands; slave is mux_b.
interface mux_b_if #(
  parameter int WIDTH = 11
);
  logic [WIDTH-1:0] ext_in;
  logic [WIDTH-1:0] data_memory_in;
  logic             sel_B;
  logic             load_en;
  logic [WIDTH-1:0] mux_B_out;
  logic [WIDTH-1:0] mux_B_q;
  logic             sel_q;

  modport master (
    output ext_in, data_memory_in, sel_B, load_en,
    input  mux_B_out, mux_B_q, sel_q
  );

  modport slave (
    input  ext_in, data_memory_in, sel_B, load_en,
    output mux_B_out, mux_B_q, sel_q
  );
endinterface

// File: rtl/mux_b.sv
// mux_b -- operand-B selector with an optional registered copy.
//   clk    : rising-edge clock, used only by the registered copy
//   rst_n  : asynchronous active-low reset of the registered copy
//   bus    : mux_b_if slave modport (operands, select, load enable, outputs)
// mux_B_out is a pure combinational 2:1 select; mux_B_q/sel_q capture it
// when load_en is high and hold otherwise.
module mux_b #(
  parameter int WIDTH = 11
) (
  input  logic   clk,
  input  logic   rst_n,
  mux_b_if.slave bus
);

  logic [WIDTH-1:0] mux_b_out_c;
  logic [WIDTH-1:0] mux_b_d;
  logic [WIDTH-1:0] mux_b_q;
  logic             sel_d;
  logic             sel_q;

  // Unknown select yields all-X in simulation instead of a bitwise merge of
  // the two operands; synthesis treats the default as don't-care.
  always_comb begin
    mux_b_out_c = '0;
    case (bus.sel_B)
      1'b0:    mux_b_out_c = bus.ext_in;
      1'b1:    mux_b_out_c = bus.data_memory_in;
      default: mux_b_out_c = 'x;
    endcase
  end

  // ---- registered copy: next-state ----
  always_comb begin
    mux_b_d = mux_b_q;
    sel_d   = sel_q;
    if (bus.load_en) begin
      mux_b_d = mux_b_out_c;
      sel_d   = bus.sel_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_b_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      mux_b_q <= mux_b_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.mux_B_out = mux_b_out_c;
  assign bus.mux_B_q   = mux_b_q;
  assign bus.sel_q     = sel_q;

endmodule

// File: tb/tb_mux_b.sv
module tb_mux_b;
  localparam int WIDTH = 11;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_b_if #(.WIDTH(WIDTH)) bus ();

  mux_b #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.load_en        = 1'b1;
    bus.sel_B          = 1'b1;
    bus.ext_in         = 11'h000;
    bus.data_memory_in = 11'h123;
    #1;
    checks++;
    if (bus.mux_B_q !== 11'h000) begin
      errors++; $display("FAIL reset_q: got %h expected %h", bus.mux_B_q, 11'h000);
    end
    checks++;
    if (bus.sel_q !== 1'b0) begin
      errors++; $display("FAIL reset_sel_q: got %b expected %b", bus.sel_q, 1'b0);
    end
    // outputs still work while reset is held
    checks++;
    if (bus.mux_B_out !== 11'h123) begin
      errors++; $display("FAIL reset_out: got %h expected %h", bus.mux_B_out, 11'h123);
    end
    // clock edges with load_en=1 must not load while in reset
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.mux_B_q !== 11'h000 || bus.sel_q !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got q=%h sel_q=%b expected q=000 sel_q=0", bus.mux_B_q, bus.sel_q);
    end
    @(negedge clk);
    bus.load_en = 1'b0;
    rst_n       = 1'b1;
  endtask

  task automatic test_select_follow();
    bus.ext_in         = 11'h000;
    bus.data_memory_in = 11'h049;
    bus.sel_B          = 1'b1;
    #1;
    checks++;
    if (bus.mux_B_out !== 11'h049) begin
      errors++; $display("FAIL follow_049: got %h expected %h", bus.mux_B_out, 11'h049);
    end
    bus.data_memory_in = 11'h749;
    #1;
    checks++;
    if (bus.mux_B_out !== 11'h749) begin
      errors++; $display("FAIL follow_749: got %h expected %h", bus.mux_B_out, 11'h749);
    end
  endtask

  task automatic test_sel_toggle();
    logic       sels [3] = '{1'b0, 1'b1, 1'b0};
    logic [10:0] exp [3] = '{11'h000, 11'h749, 11'h000};
    bus.ext_in         = 11'h000;
    bus.data_memory_in = 11'h749;
    for (int i = 0; i < 3; i++) begin
      bus.sel_B = sels[i];
      #1;
      checks++;
      if (bus.mux_B_out !== exp[i]) begin
        errors++; $display("FAIL toggle_%0d: got %h expected %h", i, bus.mux_B_out, exp[i]);
      end
    end
  endtask

  task automatic test_unselected();
    logic [10:0] vals [3] = '{11'h000, 11'h064, 11'h000};
    bus.sel_B          = 1'b0;
    bus.data_memory_in = 11'h749;
    for (int i = 0; i < 3; i++) begin
      bus.ext_in = vals[i];
      #1;
      checks++;
      if (bus.mux_B_out !== vals[i]) begin
        errors++; $display("FAIL ext_follow_%0d: got %h expected %h", i, bus.mux_B_out, vals[i]);
      end
    end
    bus.sel_B = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ext_in = (i == 1) ? 11'h3A5 : 11'h064;
      #1;
      checks++;
      if (bus.mux_B_out !== 11'h749) begin
        errors++; $display("FAIL ext_ignored_%0d: got %h expected %h", i, bus.mux_B_out, 11'h749);
      end
    end
    // full-width pattern with top bit set passes unmodified from ext_in
    bus.sel_B  = 1'b0;
    bus.ext_in = 11'h555;
    #1;
    checks++;
    if (bus.mux_B_out !== 11'h555) begin
      errors++; $display("FAIL ext_full_width: got %h expected %h", bus.mux_B_out, 11'h555);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.sel_B          = 1'b1;
    bus.data_memory_in = 11'h749;
    bus.load_en        = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.mux_B_q !== 11'h749 || bus.sel_q !== 1'b1) begin
      errors++; $display("FAIL preload: got q=%h sel_q=%b expected q=749 sel_q=1", bus.mux_B_q, bus.sel_q);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mux_B_q !== 11'h000 || bus.sel_q !== 1'b0) begin
      errors++; $display("FAIL async_reset: got q=%h sel_q=%b expected q=000 sel_q=0", bus.mux_B_q, bus.sel_q);
    end
    checks++;
    if (bus.mux_B_out !== 11'h749) begin
      errors++; $display("FAIL async_reset_out: got %h expected %h", bus.mux_B_out, 11'h749);
    end
    bus.load_en = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.mux_B_q !== 11'h000) begin
      errors++; $display("FAIL post_reset_no_load: got %h expected %h", bus.mux_B_q, 11'h000);
    end
    @(negedge clk);
    bus.load_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.mux_B_q !== 11'h749 || bus.sel_q !== 1'b1) begin
      errors++; $display("FAIL post_reset_first_load: got q=%h sel_q=%b expected q=749 sel_q=1", bus.mux_B_q, bus.sel_q);
    end
  endtask

  task automatic test_load_hold();
    @(negedge clk);
    bus.load_en        = 1'b1;
    bus.sel_B          = 1'b1;
    bus.data_memory_in = 11'h7FF;
    bus.ext_in         = 11'h000;
    @(posedge clk); #1;
    checks++;
    if (bus.mux_B_q !== 11'h7FF || bus.sel_q !== 1'b1) begin
      errors++; $display("FAIL load_7ff: got q=%h sel_q=%b expected q=7ff sel_q=1", bus.mux_B_q, bus.sel_q);
    end
    @(negedge clk);
    bus.load_en        = 1'b0;
    bus.sel_B          = 1'b0;
    bus.ext_in         = 11'h0AA;
    bus.data_memory_in = 11'h111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.mux_B_q !== 11'h7FF || bus.sel_q !== 1'b1) begin
      errors++; $display("FAIL hold_7ff: got q=%h sel_q=%b expected q=7ff sel_q=1", bus.mux_B_q, bus.sel_q);
    end
    checks++;
    if (bus.mux_B_out !== 11'h0AA) begin
      errors++; $display("FAIL hold_out: got %h expected %h", bus.mux_B_out, 11'h0AA);
    end
  endtask

  task automatic test_back_to_back();
    logic        sels [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [10:0] exts [4] = '{11'h400, 11'h001, 11'h2C3, 11'h0F0};
    logic [10:0] dms  [4] = '{11'h0FF, 11'h6B2, 11'h7FE, 11'h013};
    logic [10:0] exp  [4] = '{11'h400, 11'h6B2, 11'h2C3, 11'h013};
    logic [10:0] prev_q;
    logic        prev_sel;
    @(negedge clk);
    bus.load_en = 1'b1;
    prev_q   = 11'h7FF;
    prev_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sel_B          = sels[i];
      bus.ext_in         = exts[i];
      bus.data_memory_in = dms[i];
      #1;
      // registered copy still shows the previous value before the edge
      checks++;
      if (bus.mux_B_q !== prev_q || bus.sel_q !== prev_sel) begin
        errors++; $display("FAIL lag_pre_%0d: got q=%h sel_q=%b expected q=%h sel_q=%b", i, bus.mux_B_q, bus.sel_q, prev_q, prev_sel);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.mux_B_q !== exp[i] || bus.sel_q !== sels[i]) begin
        errors++; $display("FAIL lag_post_%0d: got q=%h sel_q=%b expected q=%h sel_q=%b", i, bus.mux_B_q, bus.sel_q, exp[i], sels[i]);
      end
      prev_q   = exp[i];
      prev_sel = sels[i];
      @(negedge clk);
    end
    bus.load_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_select_follow();
    test_sel_toggle();
    test_unselected();
    test_async_reset();
    test_load_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end
endmodule
